vt52_command_engine: RTL

VT52_COMMAND_ENGINE -- requirements
Module: vt52_command_engine

---
 rtl/vt52_command_engine.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/vt52_command_engine.sv
// VT52 terminal command engine: decodes the received byte stream into character
// buffer, scroll register and cursor writes on a circular screen buffer.
module vt52_command_engine #(
    parameter int ROWS      = 25,
    parameter int COLS      = 80,
    parameter int ROW_BITS  = 5,
    parameter int COL_BITS  = 7,
    parameter int ADDR_BITS = 11,
    parameter int TAB_WIDTH = 8,
    parameter int AUTOWRAP  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           data,
    input  logic                 valid,
    output logic                 ready,
    output logic [7:0]           new_char,
    output logic [ADDR_BITS-1:0] new_char_address,
    output logic                 new_char_wen,
    output logic [ADDR_BITS-1:0] new_first_char,
    output logic                 new_first_char_wen,
    output logic [COL_BITS-1:0]  new_cursor_x,
    output logic [ROW_BITS-1:0]  new_cursor_y,
    output logic                 new_cursor_wen
);

    localparam logic [ADDR_BITS-1:0] SIZE         = ADDR_BITS'(ROWS * COLS);
    localparam logic [ADDR_BITS-1:0] LAST_CELL    = ADDR_BITS'(ROWS * COLS - 1);
    localparam logic [ADDR_BITS-1:0] LAST_ROW_OFF = ADDR_BITS'((ROWS - 1) * COLS);
    localparam logic [ADDR_BITS-1:0] COLS_A       = ADDR_BITS'(COLS);
    localparam logic [COL_BITS-1:0]  X_MAX        = COL_BITS'(COLS - 1);
    localparam logic [ROW_BITS-1:0]  Y_MAX        = ROW_BITS'(ROWS - 1);

    typedef enum logic [2:0] {
        INIT_CLEAR, IDLE, ESC, ESC_Y_ROW, ESC_Y_COL, CLEAR, SCROLL
    } state_t;

    state_t               state;
    logic [COL_BITS-1:0]  cur_x;
    logic [ROW_BITS-1:0]  cur_y;
    logic [ADDR_BITS-1:0] first_char;
    logic [ADDR_BITS-1:0] clr_off;      // current fill offset relative to first_char
    logic [ADDR_BITS-1:0] clr_end;      // last fill offset, inclusive
    logic                 init_pulse;
    logic                 scroll_pulse;
    logic                 accept;

    assign accept = valid && ready;

    // (a + b) mod SIZE for a, b < SIZE without leaving ADDR_BITS
    function automatic logic [ADDR_BITS-1:0] wrap_add(input logic [ADDR_BITS-1:0] a,
                                                      input logic [ADDR_BITS-1:0] b);
        if (a >= SIZE - b) return a - (SIZE - b);
        return a + b;
    endfunction

    function automatic logic [ADDR_BITS-1:0] cell_off(input logic [COL_BITS-1:0] x,
                                                      input logic [ROW_BITS-1:0] y);
        return ADDR_BITS'(y) * COLS_A + ADDR_BITS'(x);
    endfunction

    function automatic logic [COL_BITS-1:0] tab_stop(input logic [COL_BITS-1:0] x);
        int t;
        t = (int'(x) / TAB_WIDTH + 1) * TAB_WIDTH;
        if (t > COLS - 1) t = COLS - 1;
        return COL_BITS'(t);
    endfunction

    // ESC Y coordinate byte: offset by 0x20, clamped to [0, lim]
    function automatic int clamp_coord(input logic [7:0] b, input int lim);
        int v;
        v = int'(b) - 32;
        if (v < 0) v = 0;
        if (v > lim) v = lim;
        return v;
    endfunction

    task automatic goto_state(input state_t s);
        state <= s;
        ready <= (s == IDLE) || (s == ESC) || (s == ESC_Y_ROW) || (s == ESC_Y_COL);
    endtask

    // cursor strobe only fires when the position actually changes
    task automatic move_cursor(input logic [COL_BITS-1:0] nx, input logic [ROW_BITS-1:0] ny);
        cur_x          <= nx;
        cur_y          <= ny;
        new_cursor_x   <= nx;
        new_cursor_y   <= ny;
        new_cursor_wen <= (nx != cur_x) || (ny != cur_y);
    endtask

    task automatic start_scroll();
        clr_off      <= LAST_ROW_OFF;
        clr_end      <= LAST_CELL;
        scroll_pulse <= 1'b1;
        goto_state(SCROLL);
    endtask

    task automatic line_feed(input logic [COL_BITS-1:0] nx);
        if (cur_y < Y_MAX) begin
            move_cursor(nx, cur_y + ROW_BITS'(1));
        end else begin
            move_cursor(nx, cur_y);
            start_scroll();
        end
    endtask

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= INIT_CLEAR;
            ready              <= 1'b0;
            cur_x              <= '0;
            cur_y              <= '0;
            first_char         <= '0;
            clr_off            <= '0;
            clr_end            <= LAST_CELL;
            init_pulse         <= 1'b1;
            scroll_pulse       <= 1'b0;
            new_char           <= '0;
            new_char_address   <= '0;
            new_char_wen       <= 1'b0;
            new_first_char     <= '0;
            new_first_char_wen <= 1'b0;
            new_cursor_x       <= '0;
            new_cursor_y       <= '0;
            new_cursor_wen     <= 1'b0;
        end else begin
            new_char_wen       <= 1'b0;
            new_first_char_wen <= 1'b0;
            new_cursor_wen     <= 1'b0;

            case (state)
                // fill states: one 0x20 per cycle from clr_off to clr_end
                INIT_CLEAR, CLEAR, SCROLL: begin
                    if (scroll_pulse) begin
                        scroll_pulse       <= 1'b0;
                        first_char         <= wrap_add(first_char, COLS_A);
                        new_first_char     <= wrap_add(first_char, COLS_A);
                        new_first_char_wen <= 1'b1;
                    end else begin
                        if (init_pulse) begin
                            init_pulse         <= 1'b0;
                            new_first_char     <= '0;
                            new_first_char_wen <= 1'b1;
                            new_cursor_x       <= '0;
                            new_cursor_y       <= '0;
                            new_cursor_wen     <= 1'b1;
                        end
                        new_char         <= 8'h20;
                        new_char_address <= wrap_add(first_char, clr_off);
                        new_char_wen     <= 1'b1;
                        if (clr_off == clr_end) goto_state(IDLE);
                        else clr_off <= clr_off + ADDR_BITS'(1);
                    end
                end

                IDLE: begin
                    if (accept) begin
                        if (data >= 8'h20 && data <= 8'h7E) begin
                            new_char         <= data;
                            new_char_address <= wrap_add(first_char, cell_off(cur_x, cur_y));
                            new_char_wen     <= 1'b1;
                            if (cur_x < X_MAX) move_cursor(cur_x + COL_BITS'(1), cur_y);
                            else if (AUTOWRAP != 0) line_feed('0);
                        end else begin
                            case (data)
                                8'h08: move_cursor((cur_x == '0) ? cur_x : cur_x - COL_BITS'(1), cur_y);
                                8'h09: move_cursor(tab_stop(cur_x), cur_y);
                                8'h0A: line_feed(cur_x);
                                8'h0D: move_cursor('0, cur_y);
                                8'h1B: goto_state(ESC);
                                default: ;
                            endcase
                        end
                    end
                end

                ESC: begin
                    if (accept) begin
                        goto_state(IDLE);
                        case (data)
                            8'h41: move_cursor(cur_x, (cur_y == '0) ? cur_y : cur_y - ROW_BITS'(1));
                            8'h42: move_cursor(cur_x, (cur_y == Y_MAX) ? cur_y : cur_y + ROW_BITS'(1));
                            8'h43: move_cursor((cur_x == X_MAX) ? cur_x : cur_x + COL_BITS'(1), cur_y);
                            8'h44: move_cursor((cur_x == '0) ? cur_x : cur_x - COL_BITS'(1), cur_y);
                            8'h48: move_cursor('0, '0);
                            8'h59: goto_state(ESC_Y_ROW);
                            8'h4A: begin
                                clr_off <= cell_off(cur_x, cur_y);
                                clr_end <= LAST_CELL;
                                goto_state(CLEAR);
                            end
                            8'h4B: begin
                                clr_off <= cell_off(cur_x, cur_y);
                                clr_end <= cell_off(X_MAX, cur_y);
                                goto_state(CLEAR);
                            end
                            default: ;
                        endcase
                    end
                end

                ESC_Y_ROW: begin
                    if (accept) begin
                        move_cursor(cur_x, ROW_BITS'(clamp_coord(data, ROWS - 1)));
                        goto_state(ESC_Y_COL);
                    end
                end

                ESC_Y_COL: begin
                    if (accept) begin
                        move_cursor(COL_BITS'(clamp_coord(data, COLS - 1)), cur_y);
                        goto_state(IDLE);
                    end
                end

                default: goto_state(IDLE);
            endcase
        end
    end

endmodule
